aes128_cbc_block_feeder: RTL
============================

AES128_CBC_BLOCK_FEEDER -- requirements
Module: aes128_cbc_block_feeder

Interface
REQ-001 Parameter ENC_LATENCY, default 12: cycles from plain_text/vector presented stable until cipher_text is valid at the encryptor output.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that opens a new message and loads iv.
REQ-005 iv  input  128  initialisation vector, sampled only on an accepted start.
REQ-006 in_data  input  32  plaintext word stream.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_last  input  1  current block is the final block of the message; qualified on the 4th word only.
REQ-009 in_ready  output  1  block accepts an input word.
REQ-010 out_data  output  32  ciphertext word stream.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_last  output  1  final word of the final block.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 plain_text_0..plain_text_3  output  32 each  plaintext block to the encryptor; _0 = bits [31:0].
REQ-016 vector_0..vector_3  output  32 each  chaining value to the encryptor; _0 = bits [31:0].
REQ-017 cipher_text_0..cipher_text_3  input  32 each  encryptor result; _0 = bits [31:0].

Function
REQ-018 FSM states SHALL be: IDLE, LOAD, WAIT, EMIT.
REQ-019 IDLE: start SHALL load chain_reg <= iv and move to LOAD; start SHALL be ignored in every other state.
REQ-020 LOAD: in_ready=1; each in_valid&in_ready handshake stores in_data at word index wcnt (0..3, first word -> plain_text_0), wcnt+1.
REQ-021 On acceptance of word 3: latch in_last as last_blk, clear wcnt, load wait counter with ENC_LATENCY, move to WAIT.
REQ-022 in_last on words 0-2 SHALL be ignored; partial blocks are not supported.
REQ-023 vector_0..3 SHALL drive chain_reg; plain_text_0..3 SHALL stay constant from WAIT entry until the final EMIT handshake.
REQ-024 WAIT: counter decrements once per cycle; at zero, cipher_text_0..3 SHALL be captured into out_buf and chain_reg in the same cycle, then move to EMIT.
REQ-025 Latency: with word 3 accepted in cycle t, out_valid SHALL first assert in cycle t+1+ENC_LATENCY.
REQ-026 EMIT: out_valid=1, out_data = out_buf word ocnt (0 first); out_data SHALL be held stable while out_ready=0.
REQ-027 out_last SHALL be 1 only on word 3 when last_blk=1.
REQ-028 After word 3 is accepted in EMIT: go to IDLE if last_blk, otherwise go to LOAD (chain_reg keeps the previous ciphertext).
REQ-029 in_ready SHALL be 0 outside LOAD; out_valid SHALL be 0 outside EMIT; only one block is in flight.
REQ-030 Counters wcnt/ocnt are 2-bit and SHALL wrap 3->0 only on a handshake.

Reset
REQ-031 Asserting reset SHALL force IDLE and clear chain_reg, plaintext, out_buf, counters and last_blk to 0 asynchronously.
REQ-032 During reset, all outputs SHALL be 0, including in_ready, out_valid and busy.
REQ-033 Reset mid-operation SHALL discard the block in flight; the next start after release SHALL behave exactly as after power-up.

Structure
REQ-034 Package aes128_cbc_pkg SHALL hold the state typedef, word-index width and the default ENC_LATENCY constant.
REQ-035 The block SHALL be a single module with no sub-module; it is instantiated beside aes128_cbc_enc_top with its plain_text/vector/cipher_text ports connected 1:1.

Verification
REQ-036 SP800-38A CBC-AES128: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102...0f, P1 6bc1bee22e409f96e93d7e117393172a, P2 ae2d8a571e03ac9c9eb76fac45af8e51 (P2 with in_last) -> C1 7649abac8119b246cee98e9b12e9197d, C2 5086cb9b507219ee95db113a917678b2, out_last on word 3 of C2 only.
REQ-037 out_ready held low 5 cycles in EMIT -> out_valid stays 1 and out_data is unchanged; no word is lost or duplicated.
REQ-038 in_valid gaps of 3 cycles between words -> out_valid appears exactly ENC_LATENCY+1 cycles after word 3 is accepted.
REQ-039 start pulsed during WAIT -> ignored; chain_reg is unchanged and C2 is still correct.
REQ-040 reset asserted in WAIT -> busy=0, out_valid=0 immediately; a new message with the same IV then yields C1 again.
REQ-041 Single-block message (in_last set) followed by start with IV all-zero -> the second message chains from zero, not from the previous ciphertext.

Source files
------------

// File: rtl/aes128_cbc_pkg.sv
// Shared types and constants for the AES-128 CBC block feeder.
package aes128_cbc_pkg;

  localparam int unsigned WIDX_W          = 2;
  localparam int unsigned ENC_LATENCY_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    EMIT
  } state_e;

  typedef logic [WIDX_W-1:0] widx_t;

endpackage

// File: rtl/aes128_cbc_block_feeder.sv
// Packs a 32-bit plaintext stream into 128-bit blocks for an external AES-128
// encryptor, chains blocks in CBC mode and streams the ciphertext back out.
module aes128_cbc_block_feeder
  import aes128_cbc_pkg::*;
#(
  parameter int unsigned ENC_LATENCY = ENC_LATENCY_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] iv,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy,
  output logic [31:0]  plain_text_0,
  output logic [31:0]  plain_text_1,
  output logic [31:0]  plain_text_2,
  output logic [31:0]  plain_text_3,
  output logic [31:0]  vector_0,
  output logic [31:0]  vector_1,
  output logic [31:0]  vector_2,
  output logic [31:0]  vector_3,
  input  logic [31:0]  cipher_text_0,
  input  logic [31:0]  cipher_text_1,
  input  logic [31:0]  cipher_text_2,
  input  logic [31:0]  cipher_text_3
);

  localparam int unsigned CNT_W = $clog2(ENC_LATENCY + 2);

  state_e              state_q, state_d;
  widx_t               wcnt_q, wcnt_d;
  widx_t               ocnt_q, ocnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0][31:0]    pt_q, pt_d;
  logic [3:0][31:0]    obuf_q, obuf_d;
  logic [127:0]        chain_q, chain_d;
  logic                last_q, last_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic [127:0]        cipher_w;

  assign cipher_w = {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ocnt_d  = ocnt_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    obuf_d  = obuf_q;
    chain_d = chain_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          chain_d = iv;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          pt_d[wcnt_q] = in_data;
          wcnt_d       = wcnt_q + 1'b1;
          if (wcnt_q == '1) begin
            last_d  = in_last;
            cnt_d   = CNT_W'(ENC_LATENCY);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Capture on the cycle the counter reaches zero so EMIT starts
        // exactly ENC_LATENCY+1 cycles after the last word is accepted.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          obuf_d  = cipher_w;
          chain_d = cipher_w;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          ocnt_d = ocnt_q + 1'b1;
          if (ocnt_q == '1) begin
            state_d = last_q ? IDLE : LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == EMIT);
    busy_d      = (state_d != IDLE);
    out_last_d  = (state_d == EMIT) && (ocnt_d == '1) && last_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      ocnt_q      <= '0;
      cnt_q       <= '0;
      pt_q        <= '0;
      obuf_q      <= '0;
      chain_q     <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ocnt_q      <= ocnt_d;
      cnt_q       <= cnt_d;
      pt_q        <= pt_d;
      obuf_q      <= obuf_d;
      chain_q     <= chain_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign out_data     = obuf_q[ocnt_q];
  assign plain_text_0 = pt_q[0];
  assign plain_text_1 = pt_q[1];
  assign plain_text_2 = pt_q[2];
  assign plain_text_3 = pt_q[3];
  assign vector_0     = chain_q[31:0];
  assign vector_1     = chain_q[63:32];
  assign vector_2     = chain_q[95:64];
  assign vector_3     = chain_q[127:96];

endmodule
